// File: rtl/nv_nvdla_cdp_wdma_intr_ctrl.sv
// CDP write-DMA interrupt sequencer: pushes finished-layer group pointers into the
// interrupt FIFO, pops one per write-completion ack and pulses the matching done interrupt.
module nv_nvdla_cdp_wdma_intr_ctrl #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             layer_done_pvld,
    input  logic             layer_done_group,
    output logic             layer_done_prdy,
    input  logic             dma_wr_rsp_complete,
    output logic             intr_fifo_wr_pvld,
    output logic             intr_fifo_wr_pd,
    input  logic             intr_fifo_rd_pvld,
    input  logic             intr_fifo_rd_pd,
    output logic             intr_fifo_rd_prdy,
    output logic [1:0]       cdp2glb_done_intr_pd,
    output logic [CNT_W-1:0] outstanding_cnt,
    output logic             idle,
    input  logic             err_clr,
    output logic             err_unexpected_complete
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic             wr_pvld_q, wr_pvld_d;
    logic             wr_pd_q,   wr_pd_d;
    logic [1:0]       intr_q,    intr_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] pending_q,     pending_d;
    logic             err_q,     err_d;

    logic             accept;
    logic             pop;
    logic             cmpl_ok;
    logic [CNT_W-1:0] pending_post;
    logic [CNT_W-1:0] outstanding_post;

    // Handshake readies depend on registered counters only, never on the valids.
    assign layer_done_prdy   = (outstanding_q < MAX_CNT);
    assign intr_fifo_rd_prdy = (pending_q != '0);

    assign accept = layer_done_pvld && layer_done_prdy;
    assign pop    = intr_fifo_rd_pvld && intr_fifo_rd_prdy;

    // Legality is judged against the post-pop counts so a same-cycle pop cannot
    // make a legitimate completion look spurious.
    assign pending_post     = pending_q     - CNT_W'(pop);
    assign outstanding_post = outstanding_q - CNT_W'(pop);
    assign cmpl_ok          = dma_wr_rsp_complete && (pending_post < outstanding_post);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_pvld_d     = accept;
        wr_pd_d       = accept ? layer_done_group : 1'b0;
        intr_d        = 2'b00;
        outstanding_d = outstanding_post + CNT_W'(accept);
        pending_d     = pending_post + CNT_W'(cmpl_ok);
        err_d         = err_q;

        if (pop) begin
            intr_d = intr_fifo_rd_pd ? 2'b10 : 2'b01;
        end

        // A new error outranks a clear arriving in the same cycle.
        if (dma_wr_rsp_complete && !cmpl_ok) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_pvld_q     <= 1'b0;
            wr_pd_q       <= 1'b0;
            intr_q        <= 2'b00;
            outstanding_q <= '0;
            pending_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            wr_pvld_q     <= wr_pvld_d;
            wr_pd_q       <= wr_pd_d;
            intr_q        <= intr_d;
            outstanding_q <= outstanding_d;
            pending_q     <= pending_d;
            err_q         <= err_d;
        end
    end

    assign intr_fifo_wr_pvld       = wr_pvld_q;
    assign intr_fifo_wr_pd         = wr_pd_q;
    assign cdp2glb_done_intr_pd    = intr_q;
    assign outstanding_cnt         = outstanding_q;
    assign err_unexpected_complete = err_q;
    assign idle                    = (outstanding_q == '0) && !wr_pvld_q;

endmodule

// File: tb/tb_nv_nvdla_cdp_wdma_intr_ctrl.sv
// Scoreboard bench for nv_nvdla_cdp_wdma_intr_ctrl: directed stimulus pushes expected
// interrupt codes; a monitor pops and compares each interrupt pulse the DUT emits.
module tb_nv_nvdla_cdp_wdma_intr_ctrl;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             layer_done_pvld = 1'b0;
    logic             layer_done_group = 1'b0;
    logic             layer_done_prdy;
    logic             dma_wr_rsp_complete = 1'b0;
    logic             intr_fifo_wr_pvld;
    logic             intr_fifo_wr_pd;
    logic             intr_fifo_rd_pvld;
    logic             intr_fifo_rd_pd;
    logic             intr_fifo_rd_prdy;
    logic [1:0]       intr_pd;
    logic [CNT_W-1:0] outstanding_cnt;
    logic             idle;
    logic             err_clr = 1'b0;
    logic             err_flag;

    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    nv_nvdla_cdp_wdma_intr_ctrl #(.MAX_OUTSTANDING(4), .CNT_W(CNT_W)) dut (
        .nvdla_core_clk         (clk),
        .nvdla_core_rstn        (rstn),
        .layer_done_pvld        (layer_done_pvld),
        .layer_done_group       (layer_done_group),
        .layer_done_prdy        (layer_done_prdy),
        .dma_wr_rsp_complete    (dma_wr_rsp_complete),
        .intr_fifo_wr_pvld      (intr_fifo_wr_pvld),
        .intr_fifo_wr_pd        (intr_fifo_wr_pd),
        .intr_fifo_rd_pvld      (intr_fifo_rd_pvld),
        .intr_fifo_rd_pd        (intr_fifo_rd_pd),
        .intr_fifo_rd_prdy      (intr_fifo_rd_prdy),
        .cdp2glb_done_intr_pd   (intr_pd),
        .outstanding_cnt        (outstanding_cnt),
        .idle                   (idle),
        .err_clr                (err_clr),
        .err_unexpected_complete(err_flag)
    );

    // Behavioural interrupt FIFO sharing the core reset.
    logic       fifo_mem [8];
    logic [2:0] fifo_wp, fifo_rp;
    logic [3:0] fifo_cnt;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo_wp  <= '0;
            fifo_rp  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (intr_fifo_wr_pvld) begin
                fifo_mem[fifo_wp] <= intr_fifo_wr_pd;
                fifo_wp <= fifo_wp + 3'd1;
            end
            if (intr_fifo_rd_pvld && intr_fifo_rd_prdy) fifo_rp <= fifo_rp + 3'd1;
            fifo_cnt <= fifo_cnt + {3'd0, intr_fifo_wr_pvld}
                                 - {3'd0, intr_fifo_rd_pvld && intr_fifo_rd_prdy};
        end
    end

    assign intr_fifo_rd_pvld = (fifo_cnt != 4'd0);
    assign intr_fifo_rd_pd   = fifo_mem[fifo_rp];

    // Monitor: every interrupt pulse must match the oldest expected code.
    always @(negedge clk) begin
        if (rstn && intr_pd != 2'b00) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL intr_unexpected: got %b, required no interrupt", intr_pd);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (intr_pd !== e) begin
                    n_bad++;
                    $display("FAIL intr_order: got %b, required %b", intr_pd, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_pvld"}, {7'd0, intr_fifo_wr_pvld}, 8'd0);
        check({tag, "_wr_pd"},   {7'd0, intr_fifo_wr_pd},   8'd0);
        check({tag, "_intr"},    {6'd0, intr_pd},           8'd0);
        check({tag, "_outst"},   {5'd0, outstanding_cnt},   8'd0);
        check({tag, "_err"},     {7'd0, err_flag},          8'd0);
        check({tag, "_prdy"},    {7'd0, layer_done_prdy},   8'd1);
        check({tag, "_rd_prdy"}, {7'd0, intr_fifo_rd_prdy}, 8'd0);
        check({tag, "_idle"},    {7'd0, idle},              8'd1);
    endtask

    initial begin
        logic [4:0] thr_grp;
        logic [2:0] ord_grp;
        thr_grp = 5'b10110;   // bit i is the group of the i-th offered layer
        ord_grp = 3'b010;

        #22;
        check_reset_outputs("rst");
        @(negedge clk);
        rstn = 1'b1;
        step();

        // Single layer, group 1.
        layer_done_pvld = 1'b1; layer_done_group = 1'b1;
        step();
        layer_done_pvld = 1'b0; layer_done_group = 1'b0;
        check("t1_wr_pvld", {7'd0, intr_fifo_wr_pvld}, 8'd1);
        check("t1_wr_pd",   {7'd0, intr_fifo_wr_pd},   8'd1);
        check("t1_outst1",  {5'd0, outstanding_cnt},   8'd1);
        check("t1_busy",    {7'd0, idle},              8'd0);
        step();
        check("t1_wr_pvld_once", {7'd0, intr_fifo_wr_pvld}, 8'd0);
        step(); step(); step();
        dma_wr_rsp_complete = 1'b1; exp_q.push_back(2'b10);
        step();
        dma_wr_rsp_complete = 1'b0;
        check("t1_rd_prdy", {7'd0, intr_fifo_rd_prdy}, 8'd1);
        step();
        check("t1_intr",   {6'd0, intr_pd},         8'h02);
        check("t1_outst0", {5'd0, outstanding_cnt}, 8'd0);
        check("t1_idle",   {7'd0, idle},            8'd1);
        step();
        check("t1_intr_once", {6'd0, intr_pd}, 8'h00);

        // Throttle at four outstanding layers.
        layer_done_pvld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            layer_done_group = thr_grp[i];
            step();
        end
        check("t2_full_cnt",  {5'd0, outstanding_cnt}, 8'd4);
        check("t2_full_prdy", {7'd0, layer_done_prdy}, 8'd0);
        dma_wr_rsp_complete = 1'b1; exp_q.push_back(2'b01);
        step();
        dma_wr_rsp_complete = 1'b0;
        check("t2_still_full", {5'd0, outstanding_cnt}, 8'd4);
        step();
        check("t2_prdy_back", {7'd0, layer_done_prdy}, 8'd1);
        check("t2_cnt3",      {5'd0, outstanding_cnt}, 8'd3);
        step();
        layer_done_pvld = 1'b0; layer_done_group = 1'b0;
        check("t2_fifth_acc", {5'd0, outstanding_cnt}, 8'd4);
        exp_q.push_back(2'b10); exp_q.push_back(2'b10);
        exp_q.push_back(2'b01); exp_q.push_back(2'b10);
        dma_wr_rsp_complete = 1'b1;
        repeat (4) step();
        dma_wr_rsp_complete = 1'b0;
        repeat (6) step();
        check("t2_drained", {5'd0, outstanding_cnt}, 8'd0);
        check("t2_idle",    {7'd0, idle},            8'd1);

        // Ordering across back-to-back completions.
        layer_done_pvld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            layer_done_group = ord_grp[i];
            step();
        end
        layer_done_pvld = 1'b0; layer_done_group = 1'b0;
        step(); step();
        for (int i = 0; i < 3; i++) begin
            dma_wr_rsp_complete = 1'b1;
            exp_q.push_back(ord_grp[i] ? 2'b10 : 2'b01);
            step();
        end
        dma_wr_rsp_complete = 1'b0;
        check("t3_intr_b", {6'd0, intr_pd}, 8'h02);
        step();
        check("t3_intr_c", {6'd0, intr_pd}, 8'h01);
        step();
        check("t3_intr_end", {6'd0, intr_pd},         8'h00);
        check("t3_cnt0",     {5'd0, outstanding_cnt}, 8'd0);

        // Spurious completion with nothing outstanding; clear versus new error.
        dma_wr_rsp_complete = 1'b1;
        step();
        dma_wr_rsp_complete = 1'b0;
        check("t4_err_set",  {7'd0, err_flag},          8'd1);
        check("t4_no_pop",   {7'd0, intr_fifo_rd_prdy}, 8'd0);
        check("t4_cnt0",     {5'd0, outstanding_cnt},   8'd0);
        dma_wr_rsp_complete = 1'b1; err_clr = 1'b1;
        step();
        dma_wr_rsp_complete = 1'b0;
        check("t4_err_wins", {7'd0, err_flag}, 8'd1);
        step();
        err_clr = 1'b0;
        check("t4_err_clr", {7'd0, err_flag}, 8'd0);
        check("t4_no_intr", {6'd0, intr_pd},  8'h00);

        // Accept, complete and pop together with outstanding=2, pending=1.
        layer_done_pvld = 1'b1; layer_done_group = 1'b1;
        step();
        layer_done_group = 1'b0;
        step();
        layer_done_pvld = 1'b0;
        step();
        dma_wr_rsp_complete = 1'b1; exp_q.push_back(2'b10);
        step();
        check("t5_pre_outst",   {5'd0, outstanding_cnt},   8'd2);
        check("t5_pre_pending", {7'd0, intr_fifo_rd_prdy}, 8'd1);
        layer_done_pvld = 1'b1; layer_done_group = 1'b1; exp_q.push_back(2'b01);
        step();
        layer_done_pvld = 1'b0; layer_done_group = 1'b0; dma_wr_rsp_complete = 1'b0;
        check("t5_outst_same", {5'd0, outstanding_cnt},   8'd2);
        check("t5_pend_same",  {7'd0, intr_fifo_rd_prdy}, 8'd1);
        check("t5_one_intr",   {6'd0, intr_pd},           8'h02);
        step();
        check("t5_next_intr", {6'd0, intr_pd},           8'h01);
        check("t5_outst1",    {5'd0, outstanding_cnt},   8'd1);
        check("t5_pend0",     {7'd0, intr_fifo_rd_prdy}, 8'd0);
        dma_wr_rsp_complete = 1'b1; exp_q.push_back(2'b10);
        step();
        dma_wr_rsp_complete = 1'b0;
        repeat (4) step();
        check("t5_drained", {5'd0, outstanding_cnt}, 8'd0);

        // Reset with three outstanding and one pending.
        layer_done_pvld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            layer_done_group = ord_grp[i];
            step();
        end
        layer_done_pvld = 1'b0; layer_done_group = 1'b0;
        step(); step();
        dma_wr_rsp_complete = 1'b1;
        step();
        dma_wr_rsp_complete = 1'b0;
        check("t6_pre_outst",  {5'd0, outstanding_cnt},   8'd3);
        check("t6_pre_pend",   {7'd0, intr_fifo_rd_prdy}, 8'd1);
        #1 rstn = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        step(); step();
        @(negedge clk);
        rstn = 1'b1;
        repeat (8) step();
        check("t6_post_outst", {5'd0, outstanding_cnt},   8'd0);
        check("t6_post_idle",  {7'd0, idle},              8'd1);
        check("t6_post_rdy",   {7'd0, intr_fifo_rd_prdy}, 8'd0);

        check("sb_all_seen", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_cdp_wdma_intr_ctrl.md
# nv_nvdla_cdp_wdma_intr_ctrl

Interrupt sequencer for the CDP write-DMA path. It pushes the register-group pointer of each finished layer into the CDP WDMA interrupt FIFO. It pops one entry per DMA write-completion acknowledge and raises a one-cycle done interrupt toward GLB on the bit selected by the popped pointer. It limits the number of layers in flight and flags completions that arrive with no layer waiting for one.

## Interface
Parameters:
- MAX_OUTSTANDING, 4: maximum layers accepted but not yet completed (1..7).
- CNT_W, 3: width of the outstanding and pending counters; must hold MAX_OUTSTANDING.

Ports:
- nvdla_core_clk, in, 1: clock.
- nvdla_core_rstn, in, 1: reset, asynchronous, active-low.
- layer_done_pvld, in, 1: the last DMA write request of a layer has been issued.
- layer_done_group, in, 1: register group (0/1) of that layer.
- layer_done_prdy, out, 1: ready to accept a layer-done event.
- dma_wr_rsp_complete, in, 1: single-cycle pulse, one per acked (layer-final) write.
- intr_fifo_wr_pvld, out, 1: push strobe to the interrupt FIFO.
- intr_fifo_wr_pd, out, 1: group pointer being pushed.
- intr_fifo_rd_pvld, in, 1: FIFO head valid.
- intr_fifo_rd_pd, in, 1: FIFO head group pointer.
- intr_fifo_rd_prdy, out, 1: pop request.
- cdp2glb_done_intr_pd, out, 2: done interrupt pulses; bit g is for group g.
- outstanding_cnt, out, CNT_W: layers accepted and not yet signalled.
- idle, out, 1: no layer in flight and no push pending.
- err_clr, in, 1: clears err_unexpected_complete.
- err_unexpected_complete, out, 1: sticky error flag.

## Operation
- Accept: `layer_done_prdy = (outstanding_cnt < MAX_OUTSTANDING)`. This is combinational from the register only.
  - A handshake registers `intr_fifo_wr_pvld = 1` and `intr_fifo_wr_pd = layer_done_group` for exactly one cycle.
  - The same handshake increments outstanding_cnt.
- Completion: `dma_wr_rsp_complete` increments pending_cnt when `pending_cnt < outstanding_cnt`.
  - Otherwise the pulse is dropped and err_unexpected_complete is set.
  - This includes a completion while outstanding_cnt is 0.
- Pop: `intr_fifo_rd_prdy = (pending_cnt != 0)`, registered-based.
  - A pop (`rd_pvld && rd_prdy`) decrements both pending_cnt and outstanding_cnt.
  - The next cycle, `cdp2glb_done_intr_pd` is driven to `2'b01` if rd_pd = 0, or `2'b10` if rd_pd = 1, for one cycle. Otherwise it is `2'b00`.
- Simultaneous events:
  - Accept and pop in the same cycle: outstanding_cnt is unchanged.
  - Complete and pop in the same cycle: pending_cnt is unchanged.
  - For the completion legality check in that cycle, use the post-pop values, so `pending_cnt - 1 < outstanding_cnt - 1` still holds.
  - err_clr and a new error in the same cycle: the error wins (flag stays 1).
- Invariant: pending_cnt ≤ outstanding_cnt ≤ MAX_OUTSTANDING. The counters never wrap.
- `idle = (outstanding_cnt == 0) && !intr_fifo_wr_pvld`.
- The FIFO is never overflowed: depth ≥ MAX_OUTSTANDING is guaranteed by the accept throttle.

## Timing
- Reset values:
  - intr_fifo_wr_pvld = 0, intr_fifo_wr_pd = 0.
  - cdp2glb_done_intr_pd = 0.
  - outstanding_cnt = 0, pending_cnt = 0.
  - err_unexpected_complete = 0.
  - layer_done_prdy = 1, intr_fifo_rd_prdy = 0, idle = 1.
- Accept at cycle T → intr_fifo_wr_pvld high in T+1 only.
- Completion at C with the FIFO head already valid → rd_prdy high at C+1, pop at C+1, interrupt pulse at C+2.
  - Minimum completion-to-interrupt latency is 2 cycles.
- Completion that arrives before the FIFO head is valid: rd_prdy stays high until rd_pvld; the pulse follows one cycle after the pop.
- Back-to-back completions are counted every cycle. Pops sustain 1 per cycle, so there are no lost pulses.
- Reset mid-operation: all counters and pending pushes are discarded and no interrupt is emitted. The FIFO shares nvdla_core_rstn and empties too.

## Test plan
- Single layer, group 1: accept at T; complete at T+5 → wr_pvld/pd = 1/1 at T+1; rd_prdy at T+6; intr_pd = 2'b10 at T+7; outstanding 1→0; idle = 1.
- Throttle (MAX = 4): offer 5 layers back-to-back → 4 accepted, prdy = 0 with count = 4. One complete+pop → prdy = 1 next cycle, 5th accepted.
- Ordering: groups 0, 1, 0 accepted, then 3 completions on consecutive cycles → intr_pd 01, 10, 01 on consecutive cycles; count ends at 0.
- Spurious completion with outstanding = 0 → error = 1, no pop, no interrupt. err_clr → 0 next cycle.
- Simultaneous accept, complete and pop with outstanding = 2, pending = 1 → outstanding stays 2, pending stays 1, one interrupt.
- Reset asserted with 3 layers outstanding and 1 pending → all outputs at reset values; no interrupt after release.
